// File: rtl/mac_layer_seq.sv
// mac_layer_seq: sequencer for one fully-connected SNN layer.
//
// For every output neuron the shared 8x8 signed MAC is cleared, then N_IN
// input/weight pairs are streamed into it from synchronous-read RAMs. The
// accumulator is then saturated to 8 bits and written to the output RAM.
// One done pulse marks the end of the layer.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start           begin a layer (only looked at in IDLE)
//   abort           synchronous abort, any state, wins over start
//   in_addr         input RAM read address (data valid next cycle)
//   wt_addr         weight RAM read address (data valid next cycle)
//   mac_clr_n       MAC clear, 0 clears the accumulator at the next edge
//   mac_zero        forces the MAC operands to 0
//   mac_acc/of/uf   MAC accumulator and overflow/underflow flags
//   out_we/addr/data output RAM write port
//   busy            high in every state except IDLE
//   done            one-cycle pulse at layer completion
//   state_dbg       current FSM state, for debug/checkers
//
// Handshake: start is a level sampled only while idle; the layer runs to
// completion (or abort) regardless of start. Each out_we pulse is a single
// complete write, there is no back-pressure from the output RAM.
module mac_layer_seq #(
   parameter int N_IN   = 784,
   parameter int N_OUT  = 32,
   parameter int IN_AW  = $clog2(N_IN),
   parameter int WT_AW  = $clog2(N_IN * N_OUT),
   parameter int OUT_AW = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   output logic [IN_AW-1:0]  in_addr,
   output logic [WT_AW-1:0]  wt_addr,
   output logic              mac_clr_n,
   output logic              mac_zero,
   input  logic [25:0]       mac_acc,
   input  logic              mac_of,
   input  logic              mac_uf,
   output logic              out_we,
   output logic [OUT_AW-1:0] out_addr,
   output logic [7:0]        out_data,
   output logic              busy,
   output logic              done,
   output logic [2:0]        state_dbg
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLR   = 3'd1,
      S_ACCUM = 3'd2,
      S_DRAIN = 3'd3,
      S_WRITE = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   localparam logic [IN_AW-1:0]  IN_LAST  = IN_AW'(N_IN - 1);
   localparam logic [OUT_AW-1:0] OUT_LAST = OUT_AW'(N_OUT - 1);

   state_t              state, state_nxt;
   logic [IN_AW-1:0]    in_idx, in_idx_nxt;
   logic [OUT_AW-1:0]   out_idx, out_idx_nxt;
   logic [WT_AW-1:0]    wt_ptr, wt_ptr_nxt;
   logic                vld_d;
   logic [7:0]          sat_data;
   logic                unused_acc_bits;

   // ------------------------------------------------------------------
   // State and index registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         in_idx  <= '0;
         out_idx <= '0;
         wt_ptr  <= '0;
         vld_d   <= 1'b0;
      end else begin
         state   <= state_nxt;
         in_idx  <= in_idx_nxt;
         out_idx <= out_idx_nxt;
         wt_ptr  <= wt_ptr_nxt;
         // RAM data appears one cycle after its address, so the operand
         // enable is the ACCUM state delayed by one cycle. This yields the
         // ACCUM cycles after the first plus DRAIN: exactly N_IN operands.
         vld_d   <= !abort && (state == S_ACCUM);
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_nxt   = state;
      in_idx_nxt  = in_idx;
      out_idx_nxt = out_idx;
      wt_ptr_nxt  = wt_ptr;

      if (abort) begin
         state_nxt   = S_IDLE;
         in_idx_nxt  = '0;
         out_idx_nxt = '0;
         wt_ptr_nxt  = '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  state_nxt   = S_CLR;
                  out_idx_nxt = '0;
                  wt_ptr_nxt  = '0;
               end
            end
            S_CLR: begin
               in_idx_nxt = '0;
               state_nxt  = S_ACCUM;
            end
            S_ACCUM: begin
               // The weight address is a running pointer that advances once
               // per fetched pair. Rows are contiguous, so it equals
               // out_idx*N_IN+in_idx without a multiplier.
               wt_ptr_nxt = wt_ptr + WT_AW'(1);
               if (in_idx == IN_LAST) begin
                  state_nxt = S_DRAIN;
               end else begin
                  in_idx_nxt = in_idx + IN_AW'(1);
               end
            end
            S_DRAIN: begin
               state_nxt = S_WRITE;
            end
            S_WRITE: begin
               if (out_idx == OUT_LAST) begin
                  state_nxt = S_DONE;
               end else begin
                  out_idx_nxt = out_idx + OUT_AW'(1);
                  state_nxt   = S_CLR;
               end
            end
            S_DONE: begin
               state_nxt = S_IDLE;
            end
            default: begin
               state_nxt = S_IDLE;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Saturation: overflow has priority even though both flags together
   // cannot happen.
   // ------------------------------------------------------------------
   always_comb begin
      if (mac_of) begin
         sat_data = 8'h7F;
      end else if (mac_uf) begin
         sat_data = 8'h80;
      end else begin
         sat_data = mac_acc[17:10];
      end
   end

   assign unused_acc_bits = ^{mac_acc[25:18], mac_acc[9:0]};

   // ------------------------------------------------------------------
   // Outputs: decoded from registered state, so they all sit at their
   // reset values the moment rst_n falls. abort gates the two strobes
   // combinationally so nothing is written or signalled in its cycle.
   // ------------------------------------------------------------------
   assign in_addr   = in_idx;
   assign wt_addr   = wt_ptr;
   assign mac_clr_n = (state == S_ACCUM) || (state == S_DRAIN) || (state == S_WRITE);
   assign mac_zero  = !vld_d;
   assign out_we    = (state == S_WRITE) && !abort;
   assign out_addr  = out_idx;
   assign out_data  = (state == S_WRITE) ? sat_data : 8'h00;
   assign busy      = (state != S_IDLE);
   assign done      = (state == S_DONE) && !abort;
   assign state_dbg = state;

endmodule

// File: tb/tb_mac_layer_seq.sv
// tb_mac_layer_seq: randomized scoreboard bench for mac_layer_seq.
//
// The bench holds the input/weight RAMs (synchronous read) and a stand-in
// MAC whose flags report when the accumulator leaves the range that
// mac_acc[17:10] can represent. Expected neuron results are plain dot
// products saturated to 8 bits; expected timing comes from the per-neuron
// cycle count N_IN+3.
module tb_mac_layer_seq;

   localparam int N_IN   = 16;
   localparam int N_OUT  = 3;
   localparam int IN_AW  = 4;
   localparam int WT_AW  = 6;
   localparam int OUT_AW = 2;
   localparam int NPC    = N_IN + 3;           // cycles per neuron
   localparam int DLAT   = N_OUT * NPC + 1;    // start cycle -> done cycle
   localparam int W      = OUT_AW + 8;

   // ------------------------------------------------------------------
   // Clock / reset
   // ------------------------------------------------------------------
   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ------------------------------------------------------------------
   // DUT
   // ------------------------------------------------------------------
   logic              start, abort;
   logic [IN_AW-1:0]  in_addr;
   logic [WT_AW-1:0]  wt_addr;
   logic              mac_clr_n, mac_zero;
   logic [25:0]       mac_acc;
   logic              mac_of, mac_uf;
   logic              out_we;
   logic [OUT_AW-1:0] out_addr;
   logic [7:0]        out_data;
   logic              busy, done;
   logic [2:0]        state_dbg;

   mac_layer_seq #(
      .N_IN  (N_IN),
      .N_OUT (N_OUT),
      .IN_AW (IN_AW),
      .WT_AW (WT_AW),
      .OUT_AW(OUT_AW)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .abort    (abort),
      .in_addr  (in_addr),
      .wt_addr  (wt_addr),
      .mac_clr_n(mac_clr_n),
      .mac_zero (mac_zero),
      .mac_acc  (mac_acc),
      .mac_of   (mac_of),
      .mac_uf   (mac_uf),
      .out_we   (out_we),
      .out_addr (out_addr),
      .out_data (out_data),
      .busy     (busy),
      .done     (done),
      .state_dbg(state_dbg)
   );

   // ------------------------------------------------------------------
   // Memories and MAC stand-in
   // ------------------------------------------------------------------
   logic signed [7:0]  in_mem [N_IN];
   logic signed [7:0]  wt_mem [N_IN*N_OUT];
   logic signed [7:0]  in_q = 8'sd0;
   logic signed [7:0]  wt_q = 8'sd0;
   logic signed [7:0]  opa, opb;
   logic signed [25:0] acc = 26'sd0;

   always @(posedge clk) begin
      in_q <= in_mem[in_addr];
      wt_q <= (int'(wt_addr) < N_IN*N_OUT) ? wt_mem[wt_addr] : 8'sd0;
   end

   assign opa = mac_zero ? 8'sd0 : in_q;
   assign opb = mac_zero ? 8'sd0 : wt_q;

   always @(posedge clk) begin
      if (!mac_clr_n) acc <= 26'sd0;
      else            acc <= acc + 26'(int'(opa) * int'(opb));
   end

   assign mac_acc = acc;
   assign mac_of  = int'(acc) > 131071;
   assign mac_uf  = int'(acc) < -131072;

   // ------------------------------------------------------------------
   // Scoreboard
   // ------------------------------------------------------------------
   logic [W-1:0] exp_q[$];
   int           exp_cyc_q[$];
   int           done_cyc_q[$];
   int           checks = 0;
   int           errors = 0;
   int           zcnt   = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [7:0] ref_neuron(input int k);
      int sum;
      sum = 0;
      for (int i = 0; i < N_IN; i++) sum += int'(in_mem[i]) * int'(wt_mem[k*N_IN + i]);
      if (sum > 131071)       return 8'h7F;
      else if (sum < -131072) return 8'h80;
      else                    return sum[17:10];
   endfunction

   // Expected writes of the first n_wr neurons of a layer whose start is
   // sampled in cycle c, plus its done pulse if the layer is to finish.
   task automatic push_layer(input int c, input int n_wr, input bit with_done);
      for (int k = 0; k < n_wr; k++) begin
         exp_q.push_back({OUT_AW'(k), ref_neuron(k)});
         exp_cyc_q.push_back(c + (k + 1) * NPC);
      end
      if (with_done) done_cyc_q.push_back(c + DLAT);
   endtask

   // ------------------------------------------------------------------
   // Driver tasks (inputs change 1 time unit after the rising edge)
   // ------------------------------------------------------------------
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic fill_random();
      for (int i = 0; i < N_IN; i++) in_mem[i] = 8'($urandom_range(0, 255));
      for (int i = 0; i < N_IN*N_OUT; i++) wt_mem[i] = 8'($urandom_range(0, 255));
   endtask

   task automatic run_layer();
      push_layer(cyc, N_OUT, 1'b1);
      start = 1'b1;
      step(1);
      start = 1'b0;
      step(DLAT + 1);
      chk("idle_after_done", int'(busy), 0);
   endtask

   task automatic run_abort(input int at, input int n_wr);
      push_layer(cyc, n_wr, 1'b0);
      start = 1'b1;
      step(1);
      start = 1'b0;
      step(at - 1);
      abort = 1'b1;
      step(1);
      abort = 1'b0;
      chk("idle_after_abort", int'(busy), 0);
      step(DLAT);
   endtask

   // ------------------------------------------------------------------
   // Stimulus and monitor
   // ------------------------------------------------------------------
   initial begin
      int c;
      rst_n = 1'b0;
      start = 1'b0;
      abort = 1'b0;
      fill_random();

      fork
         forever begin
            @(negedge clk);
            if (rst_n) begin
               if (!mac_zero) zcnt++;
               if (out_we) begin
                  chk("write_expected", int'(exp_q.size() > 0), 1);
                  if (exp_q.size() > 0) begin
                     chk("write_addr_data", int'({out_addr, out_data}), int'(exp_q.pop_front()));
                     chk("write_cycle", cyc, exp_cyc_q.pop_front());
                  end
                  chk("operand_cycles", zcnt, N_IN);
                  zcnt = 0;
               end
               if (done) begin
                  chk("done_expected", int'(done_cyc_q.size() > 0), 1);
                  if (done_cyc_q.size() > 0) chk("done_cycle", cyc, done_cyc_q.pop_front());
               end
               if (!busy) zcnt = 0;
            end
         end
      join_none

      // Reset values
      step(3);
      chk("rst_busy", int'(busy), 0);
      chk("rst_mac_clr_n", int'(mac_clr_n), 0);
      chk("rst_mac_zero", int'(mac_zero), 1);
      chk("rst_out_we", int'(out_we), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_out_addr", int'(out_addr), 0);
      chk("rst_out_data", int'(out_data), 0);
      rst_n = 1'b1;
      step(2);

      // Random layers
      for (int r = 0; r < 4; r++) begin
         fill_random();
         run_layer();
         step($urandom_range(0, 3));
      end

      // Saturation: row 0 overflows, row 1 random, row 2 underflows
      for (int i = 0; i < N_IN; i++) begin
         in_mem[i]            = 8'sd127;
         wt_mem[i]            = 8'sd127;
         wt_mem[N_IN + i]     = 8'($urandom_range(0, 255));
         wt_mem[2*N_IN + i]   = -8'sd128;
      end
      run_layer();

      // start pulsed again while busy has no effect
      fill_random();
      push_layer(cyc, N_OUT, 1'b1);
      start = 1'b1;
      step(1);
      start = 1'b0;
      step(4);
      start = 1'b1;
      step(1);
      start = 1'b0;
      step(DLAT);
      chk("idle_after_restart_try", int'(busy), 0);

      // Abort during ACCUM of neuron 0, and in the WRITE cycle of neuron 1
      run_abort(9, 0);
      run_abort(2 * NPC, 1);

      // abort together with start in IDLE
      start = 1'b1;
      abort = 1'b1;
      step(1);
      start = 1'b0;
      abort = 1'b0;
      chk("abort_beats_start", int'(busy), 0);
      step(3);
      run_layer();

      // Reset during ACCUM of neuron 1
      fill_random();
      c = cyc;
      push_layer(c, 1, 1'b0);
      start = 1'b1;
      step(1);
      start = 1'b0;
      step(NPC + 2);
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_mac_clr_n", int'(mac_clr_n), 0);
      chk("midrst_mac_zero", int'(mac_zero), 1);
      chk("midrst_out_we", int'(out_we), 0);
      step(2);
      rst_n = 1'b1;
      step(1);
      run_layer();

      // start held: back-to-back layers
      fill_random();
      c = cyc;
      push_layer(c, N_OUT, 1'b1);
      push_layer(c + DLAT + 1, N_OUT, 1'b1);
      start = 1'b1;
      step(DLAT + 6);
      start = 1'b0;
      step(DLAT + 2);
      chk("idle_after_b2b", int'(busy), 0);

      step(4);
      chk("writes_left", exp_q.size(), 0);
      chk("dones_left", done_cyc_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mac_layer_seq.md
Name: mac_layer_seq

Overview:
- Sequencer for one fully-connected SNN layer built around the shared 8x8 signed MAC (26-bit accumulator with of/uf flags).
- For each output neuron it clears the MAC and streams N_IN input/weight pairs from synchronous RAMs into it.
- It then saturates the accumulator to 8 bits and writes the result to output RAM.
- It sits between the top-level layer FSM (start/done) and the MAC plus the input, weight and output memories.

Parameters:
N_IN, 784, inputs per neuron (>=2)
N_OUT, 32, neurons in layer (>=1)
IN_AW, $clog2(N_IN), input RAM address width
WT_AW, $clog2(N_IN*N_OUT), weight RAM address width
OUT_AW, $clog2(N_OUT) (min 1), output RAM address width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin layer; sampled only in IDLE
abort  in  1  synchronous abort, any state
in_addr  out  IN_AW  input RAM read address (data valid next cycle)
wt_addr  out  WT_AW  weight RAM read address (data valid next cycle)
mac_clr_n  out  1  to MAC clr_n; 0 clears acc at next edge
mac_zero  out  1  forces MAC a/b operands to 0 at operand mux
mac_acc  in  26  MAC accumulator
mac_of  in  1  MAC overflow flag
mac_uf  in  1  MAC underflow flag
out_we  out  1  output RAM write enable
out_addr  out  OUT_AW  output RAM write address
out_data  out  8  saturated neuron result
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at layer completion

Behaviour:
- Reset (async, rst_n=0), all registered:
  - state=IDLE; in_idx=0, out_idx=0, vld_d=0.
  - mac_clr_n=0, mac_zero=1, out_we=0, out_addr=0, out_data=0, done=0, busy=0.
- States: IDLE, CLR, ACCUM, DRAIN, WRITE, DONE.
- IDLE:
  - mac_clr_n=0, mac_zero=1.
  - start=1 -> CLR with out_idx=0.
- CLR (1 cycle):
  - mac_clr_n=0; in_idx<=0 -> ACCUM.
- ACCUM (N_IN cycles):
  - mac_clr_n=1.
  - in_addr=in_idx; wt_addr=out_idx*N_IN+in_idx (use incrementing base register, no multiplier).
  - in_idx increments each cycle; at in_idx==N_IN-1 -> DRAIN.
- DRAIN (1 cycle):
  - No new address; the last RAM data is consumed by the MAC.
  - mac_clr_n=1 -> WRITE.
- Operand gating:
  - vld_d <= (state==ACCUM); mac_zero = !vld_d.
  - Exactly N_IN nonzero operand cycles per neuron: the ACCUM cycles after the first, plus DRAIN.
  - Non-valid cycles add 0 to acc.
- WRITE (1 cycle):
  - acc is final. out_we=1, out_addr=out_idx.
  - out_data = mac_of ? 8'h7F : mac_uf ? 8'h80 : mac_acc[17:10].
  - mac_zero=1, mac_clr_n=1.
  - out_idx==N_OUT-1 -> DONE; else out_idx++, -> CLR.
- DONE (1 cycle):
  - done=1, mac_clr_n=0 -> IDLE.
  - busy drops in the IDLE cycle after done.
- Latency:
  - Each neuron takes N_IN+3 cycles.
  - If start is sampled in cycle 0, WRITE of neuron k occurs in cycle (k+1)*(N_IN+3).
  - done is high in cycle N_OUT*(N_IN+3)+1.
- Boundary conditions:
  - start while busy: ignored; no restart, no effect on indices.
  - start held high through DONE: a new layer begins from the following IDLE cycle.
  - abort=1: next state IDLE, indices cleared, no out_we or done in or after that cycle. out_we in the abort cycle itself is forced 0.
  - abort together with start in IDLE: abort wins.
  - rst_n low mid-operation: immediate return to reset values; the output RAM keeps prior writes.
  - wt_addr runs contiguously 0..N_IN*N_OUT-1 across neurons, with no wrap within a layer.
  - of and uf both set is impossible by construction; of takes priority anyway.

Test Plan:
- N_IN=4, N_OUT=2; inputs {1,2,3,4}, weights row0 {1,1,1,1}, row1 {-1,-1,-1,-1}, in Q-format with real MAC -> acc0=10, acc1=-10. Output writes mac_acc[17:10] of each at cycles 7 and 14; done at cycle 15; exactly 2 out_we pulses.
- Inputs all 127, weights all 127, N_IN=16 -> acc exceeds 2^17, of=1 -> out_data=8'h7F. With weights all -128 -> uf=1 -> out_data=8'h80.
- Address trace check, N_IN=4, N_OUT=3:
  - wt_addr sequence 0..11 with no gaps.
  - in_addr repeats 0..3 per neuron.
  - mac_zero low for exactly 4 cycles per neuron.
- Assert start again at cycle 5 while busy -> no effect on addresses or done timing. Abort at cycle 9 -> IDLE next cycle, no further out_we, done never pulses; a fresh start then completes normally.
- Deassert rst_n during ACCUM of neuron 1 -> all outputs at reset values immediately (busy=0, mac_clr_n=0). After release, start reruns from out_idx=0.
- Start held continuously -> back-to-back layers, each done pulse spaced N_OUT*(N_IN+3)+2 cycles apart.
